// File: rtl/apb_write_scoreboard.sv
// rtl/apb_write_scoreboard.sv - logs APB write beats and checks them against a preloaded expected array.
// Optional APB_SB_DEVICE_FILTER_EN: only beats addressed to DEVICE_ID are logged.
module apb_write_scoreboard #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEV_W     = 4,
  parameter int DEPTH     = 8,
  parameter int DEVICE_ID = 0,
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  input  logic              flush,
  input  logic              apb_write,
  input  logic              ready,
  input  logic [ADDR_W-1:0] apb_addr,
  input  logic [DATA_W-1:0] apb_data,
  input  logic [DEV_W-1:0]  apb_device,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W:0]    err_count,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic              first_err_valid,
  output logic [IDX_W:0]    cap_count,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_COMPARE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [IDX_W:0]    cmp_idx;
  logic [DATA_W-1:0] log_mem [DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];

  logic           dev_match;
  logic           beat;
  logic           mismatch;
  logic           exp_wr_ok;
  logic [IDX_W:0] cap_next;
  logic [IDX_W:0] cmp_next;
  logic           unused_ok;

`ifdef APB_SB_DEVICE_FILTER_EN
  assign dev_match = (apb_device == DEV_W'(DEVICE_ID));
`else
  assign dev_match = 1'b1;
`endif

  // Address is accepted for port compatibility only; device is unused without the filter.
  assign unused_ok = ^{apb_addr, apb_device};

  assign beat      = (state == S_CAPTURE) && apb_write && ready && dev_match;
  assign cap_next  = cap_count + 1'b1;
  assign cmp_next  = cmp_idx + 1'b1;
  assign mismatch  = (log_mem[cmp_idx[IDX_W-1:0]] != exp_mem[cmp_idx[IDX_W-1:0]]);
  assign exp_wr_ok = !rst && exp_we && ((state == S_IDLE) || (state == S_DONE))
                     && ({1'b0, exp_idx} < DEPTH_L);

  assign busy    = (state == S_CAPTURE) || (state == S_COMPARE);
  assign done    = (state == S_DONE);
  assign rd_data = ({1'b0, rd_idx} < DEPTH_L) ? log_mem[rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cap_count       <= '0;
      cmp_idx         <= '0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      pass            <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state           <= S_CAPTURE;
            cap_count       <= '0;
            cmp_idx         <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
          end
        end
        S_CAPTURE: begin
          // A beat on the flush edge is logged before capture closes.
          if (beat) begin
            cap_count <= cap_next;
            if (flush || (cap_next == DEPTH_L)) state <= S_COMPARE;
          end else if (flush) begin
            state <= (cap_count == '0) ? S_DONE : S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!first_err_valid) begin
              first_err_idx   <= cmp_idx[IDX_W-1:0];
              first_err_valid <= 1'b1;
            end
          end
          cmp_idx <= cmp_next;
          if (cmp_next == cap_count) begin
            state <= S_DONE;
            pass  <= (err_count == '0) && !mismatch && (cap_count == DEPTH_L);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Log and expected arrays are plain storage: never reset.
  always_ff @(posedge clk) begin
    if (!rst && beat) log_mem[cap_count[IDX_W-1:0]] <= apb_data;
    if (exp_wr_ok) exp_mem[exp_idx] <= exp_data;
  end

endmodule

// File: tb/tb_apb_write_scoreboard.sv
// tb/tb_apb_write_scoreboard.sv - self-checking bench for apb_write_scoreboard with a queue-based model.
module tb_apb_write_scoreboard;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int VW  = 4;
  localparam int D   = 7;
  localparam int DEV = 2;
  localparam int IW  = 3;

  logic          clk = 1'b0;
  logic          rst, exp_we, start, flush, apb_write, ready;
  logic [IW-1:0] exp_idx, rd_idx, first_err_idx;
  logic [DW-1:0] exp_data, apb_data, rd_data;
  logic [AW-1:0] apb_addr;
  logic [VW-1:0] apb_device;
  logic          busy, done, pass, first_err_valid;
  logic [IW:0]   err_count, cap_count;

  logic [7:0] exp_m [D];
  int errors = 0;
  int checks = 0;

  apb_write_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .DEV_W(VW), .DEPTH(D), .DEVICE_ID(DEV)) dut (
    .clk(clk), .rst(rst), .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
    .start(start), .flush(flush), .apb_write(apb_write), .ready(ready),
    .apb_addr(apb_addr), .apb_data(apb_data), .apb_device(apb_device),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_valid(first_err_valid),
    .cap_count(cap_count), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit accepts(input logic [3:0] dv);
`ifdef APB_SB_DEVICE_FILTER_EN
    return dv == DEV[3:0];
`else
    return dv == dv;
`endif
  endfunction

  task automatic load_exp(input int i, input logic [7:0] v);
    exp_we = 1'b1; exp_idx = IW'(i); exp_data = v;
    tick;
    exp_we = 1'b0;
    exp_m[i] = v;
  endtask

  // mode 0: exact expected data, 1: entry 2 forced to 1F, 2: random mix
  task automatic do_run(input int n, input int mode, input bit noisy, input bit flush_last);
    logic [7:0] cap [$];
    logic [7:0] d;
    logic [3:0] dv;
    int k, errs, first;
    bit flushed;
    cap.delete();
    flushed = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_capture", busy, 1);
    chk("cap_clear", cap_count, 0);
    chk("err_clear", err_count, 0);
    chk("fev_clear", first_err_valid, 0);
    while (cap.size() < n) begin
      if (noisy && $urandom_range(0, 2) == 0) begin
        apb_write = 1'($urandom_range(0, 1));
        ready     = ~apb_write;
        exp_we    = 1'($urandom_range(0, 1));
        exp_idx   = IW'($urandom_range(0, D-1));
        exp_data  = 8'($urandom);
        start     = 1'($urandom_range(0, 1));
        tick;
        exp_we = 1'b0; start = 1'b0; apb_write = 1'b0; ready = 1'b0;
      end
      case (mode)
        0:       d = exp_m[cap.size()];
        1:       d = (cap.size() == 2) ? 8'h1F : exp_m[cap.size()];
        default: d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : exp_m[cap.size()];
      endcase
      dv = noisy ? 4'($urandom_range(0, 3)) : DEV[3:0];
      apb_write = 1'b1; ready = 1'b1; apb_data = d; apb_device = dv; apb_addr = 8'($urandom);
      if (accepts(dv)) begin
        cap.push_back(d);
        if (flush_last && cap.size() == n && n < D) begin
          flush = 1'b1;
          flushed = 1'b1;
        end
      end
      tick;
      apb_write = 1'b0; ready = 1'b0; flush = 1'b0;
    end
    if (n < D && !flushed) begin
      flush = 1'b1;
      tick;
      flush = 1'b0;
    end
    if (n > 0) chk("busy_compare", busy, 1);
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      tick;
      k++;
    end
    chk("done_latency", k, n);
    errs = 0;
    first = 0;
    for (int i = 0; i < n; i++) begin
      if (cap[i] !== exp_m[i]) begin
        if (errs == 0) first = i;
        errs++;
      end
    end
    chk("pass", pass, (errs == 0 && n == D) ? 1 : 0);
    chk("err_count", err_count, errs);
    chk("first_err_valid", first_err_valid, (errs > 0) ? 1 : 0);
    chk("first_err_idx", first_err_idx, first);
    chk("cap_count", cap_count, n);
    chk("busy_done", busy, 0);
    for (int i = 0; i < n; i++) begin
      rd_idx = IW'(i);
      #1;
      chk("rd_data", rd_data, cap[i]);
    end
  endtask

  initial begin
    logic [7:0] init_exp [D];
    init_exp = '{8'h1F, 8'h01, 8'h1E, 8'h01, 8'h01, 8'h1F, 8'h1F};
    rst = 1'b1; exp_we = 1'b0; start = 1'b0; flush = 1'b0; apb_write = 1'b0; ready = 1'b0;
    exp_idx = '0; exp_data = '0; apb_addr = '0; apb_data = '0; apb_device = '0; rd_idx = '0;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_cap", cap_count, 0);
    chk("rst_fev", first_err_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < D; i++) load_exp(i, init_exp[i]);

    do_run(7, 0, 1'b0, 1'b0);
    do_run(7, 1, 1'b0, 1'b0);
    do_run(3, 0, 1'b0, 1'b0);
    do_run(0, 0, 1'b0, 1'b0);
    do_run(4, 2, 1'b0, 1'b1);

    // reset while comparing a run full of mismatches
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < D; i++) begin
      apb_write = 1'b1; ready = 1'b1; apb_data = 8'h55; apb_device = DEV[3:0];
      tick;
    end
    apb_write = 1'b0; ready = 1'b0;
    tick;
    tick;
    chk("mid_compare_busy", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstc_busy", busy, 0);
    chk("rstc_done", done, 0);
    chk("rstc_pass", pass, 0);
    chk("rstc_err", err_count, 0);
    chk("rstc_cap", cap_count, 0);
    chk("rstc_fev", first_err_valid, 0);
    chk("rstc_fei", first_err_idx, 0);
    tick;
    chk("rstc_idle", busy, 0);

    for (int r = 0; r < 14; r++) begin
      if ($urandom_range(0, 1) == 1)
        load_exp($urandom_range(0, D-1), 8'($urandom_range(0, 3) == 0 ? $urandom : 32'h1F));
      do_run($urandom_range(0, D), 2, 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
